// File: rtl/btn_pkg.sv
// btn_pkg: shared constants and types for the
// push-button conditioner.
package btn_pkg;

  localparam int CLK_HZ        = 100_000_000;
  localparam int DB_MS         = 10;
  localparam int RPT_DELAY_MS  = 500;
  localparam int RPT_PERIOD_MS = 100;

  localparam int CYC_PER_MS = CLK_HZ / 1000;

  localparam int DB_CYCLES =
    DB_MS * CYC_PER_MS;
  localparam int RPT_DELAY_CYCLES =
    RPT_DELAY_MS * CYC_PER_MS;
  localparam int RPT_PERIOD_CYCLES =
    RPT_PERIOD_MS * CYC_PER_MS;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DELAY = 2'd1,
    RPT   = 2'd2
  } rpt_state_t;

  function automatic int max_int(
    input int a,
    input int b
  );
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/btn_debounce_chan.sv
// btn_debounce_chan: one button channel -- sync,
// debounce, edge pulses and auto-repeat keys.
module btn_debounce_chan
  import btn_pkg::*;
#(
  parameter int STABLE_CYCLES = DB_CYCLES,
  parameter int REPEAT_EN     = 1,
  parameter int REPEAT_DELAY  = RPT_DELAY_CYCLES,
  parameter int REPEAT_PERIOD = RPT_PERIOD_CYCLES
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_btn,
  output logic o_level,
  output logic o_press,
  output logic o_release,
  output logic o_key
);

  localparam int DW = $clog2(STABLE_CYCLES);
  localparam logic [DW-1:0] DB_LAST =
    DW'(STABLE_CYCLES - 1);

  logic          r_s1;
  logic          r_s2;
  logic          r_level;
  logic          r_press;
  logic          r_release;
  logic [DW-1:0] r_db_cnt;

  logic w_hit;
  logic w_rise;
  logic w_fall;

  // The level flips on the last cycle of an
  // unbroken disagreement window.
  assign w_hit  = (r_s2 != r_level) &&
                  (r_db_cnt == DB_LAST);
  assign w_rise = w_hit & ~r_level;
  assign w_fall = w_hit & r_level;

  // Two-flop synchroniser for the raw pin.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
    end else begin
      r_s1 <= i_btn;
      r_s2 <= r_s1;
    end
  end

  // Debounce window counter, level and edge pulses.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_db_cnt  <= '0;
      r_level   <= 1'b0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
    end else begin
      r_press   <= w_rise;
      r_release <= w_fall;
      if (r_s2 == r_level) begin
        r_db_cnt <= '0;
      end else if (w_hit) begin
        r_db_cnt <= '0;
        r_level  <= ~r_level;
      end else begin
        r_db_cnt <= r_db_cnt + 1'b1;
      end
    end
  end

  assign o_level   = r_level;
  assign o_press   = r_press;
  assign o_release = r_release;

  if (REPEAT_EN != 0) begin : g_rpt

    localparam int RMAX =
      max_int(REPEAT_DELAY, REPEAT_PERIOD);
    localparam int RW = $clog2(RMAX);
    localparam logic [RW-1:0] RD_LAST =
      RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] RP_LAST =
      RW'(REPEAT_PERIOD - 1);

    rpt_state_t    r_state;
    rpt_state_t    w_state_nxt;
    logic [RW-1:0] r_rep_cnt;
    logic [RW-1:0] w_rep_cnt_nxt;
    logic          r_key;
    logic          w_key_nxt;

    // Repeat FSM state, counter and key register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        r_state   <= IDLE;
        r_rep_cnt <= '0;
        r_key     <= 1'b0;
      end else begin
        r_state   <= w_state_nxt;
        r_rep_cnt <= w_rep_cnt_nxt;
        r_key     <= w_key_nxt;
      end
    end

    // Next state; a release always beats a repeat.
    always_comb begin
      w_state_nxt   = r_state;
      w_rep_cnt_nxt = r_rep_cnt;
      w_key_nxt     = 1'b0;
      if (w_fall) begin
        w_state_nxt   = IDLE;
        w_rep_cnt_nxt = '0;
      end else begin
        case (r_state)
          IDLE: begin
            if (w_rise) begin
              w_state_nxt   = DELAY;
              w_rep_cnt_nxt = '0;
              w_key_nxt     = 1'b1;
            end
          end
          DELAY: begin
            if (r_rep_cnt == RD_LAST) begin
              w_state_nxt   = RPT;
              w_rep_cnt_nxt = '0;
              w_key_nxt     = 1'b1;
            end else begin
              w_rep_cnt_nxt = r_rep_cnt + 1'b1;
            end
          end
          RPT: begin
            if (r_rep_cnt == RP_LAST) begin
              w_rep_cnt_nxt = '0;
              w_key_nxt     = 1'b1;
            end else begin
              w_rep_cnt_nxt = r_rep_cnt + 1'b1;
            end
          end
          default: begin
            w_state_nxt   = IDLE;
            w_rep_cnt_nxt = '0;
          end
        endcase
      end
    end

    assign o_key = r_key;

  end else begin : g_norpt

    assign o_key = r_press;

  end

endmodule

// File: rtl/btn_debounce_array.sv
// btn_debounce_array: N independent button
// conditioner channels.
module btn_debounce_array
  import btn_pkg::*;
#(
  parameter int N_BTN         = 5,
  parameter int STABLE_CYCLES = DB_CYCLES,
  parameter int REPEAT_EN     = 1,
  parameter int REPEAT_DELAY  = RPT_DELAY_CYCLES,
  parameter int REPEAT_PERIOD = RPT_PERIOD_CYCLES
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic [N_BTN-1:0] btn_in,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic [N_BTN-1:0] btn_key
);

  if (N_BTN < 1) begin : g_bad_n
    $error("N_BTN must be >= 1");
  end
  if (STABLE_CYCLES < 2) begin : g_bad_db
    $error("STABLE_CYCLES must be >= 2");
  end
  if (REPEAT_DELAY < 2) begin : g_bad_rd
    $error("REPEAT_DELAY must be >= 2");
  end
  if (REPEAT_PERIOD < 2) begin : g_bad_rp
    $error("REPEAT_PERIOD must be >= 2");
  end

  for (genvar gi = 0; gi < N_BTN; gi++) begin : g_chan
    btn_debounce_chan #(
      .STABLE_CYCLES (STABLE_CYCLES),
      .REPEAT_EN     (REPEAT_EN),
      .REPEAT_DELAY  (REPEAT_DELAY),
      .REPEAT_PERIOD (REPEAT_PERIOD)
    ) u_chan (
      .i_clk     (clk_in),
      .i_rst_n   (rst_n_in),
      .i_btn     (btn_in[gi]),
      .o_level   (btn_level[gi]),
      .o_press   (btn_press[gi]),
      .o_release (btn_release[gi]),
      .o_key     (btn_key[gi])
    );
  end

endmodule

// File: doc/btn_debounce_array.md
# btn_debounce_array

Parametrised multi-channel push-button conditioner for the BASYS 3 designs. Each channel synchronises a raw button, applies counter-based debounce with a programmable stability window, and produces a clean level, one-cycle press and release pulses, and an optional auto-repeat keystroke stream. It sits between the board button pins and the user-input FSMs, such as the calculator operand and operator entry logic.

## Interface
Parameters:
- `N_BTN`, 5: number of independent channels.
- `STABLE_CYCLES`, 1_000_000: cycles the synchronised input must differ from the current level before the level flips (10 ms at 100 MHz). Must be ≥2.
- `REPEAT_EN`, 1: 1 enables auto-repeat on `btn_key`; 0 makes `btn_key` equal `btn_press`.
- `REPEAT_DELAY`, 50_000_000: held cycles from press to the first repeat. Must be ≥2.
- `REPEAT_PERIOD`, 10_000_000: cycles between subsequent repeats. Must be ≥2.

Ports:
- `clk_in` in 1: single system clock, all logic on its rising edge.
- `rst_n_in` in 1: reset, asynchronous and active-low; clears all state.
- `btn_in` in N_BTN: raw, asynchronous button inputs, active-high.
- `btn_level` out N_BTN: debounced level.
- `btn_press` out N_BTN: one-cycle pulse on each debounced 0→1.
- `btn_release` out N_BTN: one-cycle pulse on each debounced 1→0.
- `btn_key` out N_BTN: keystroke pulse. Fires on press, then on auto-repeat while held.

## Operation
Each channel is independent; there is no interaction between channels.
- **Synchroniser:** two flops, `s1 <= btn_in[i]` and `s2 <= s1`. Both reset to 0.
- **Debounce counter `db_cnt`:**
  - Width is $clog2(STABLE_CYCLES).
  - On any edge where `s2 == level`, `db_cnt` clears to 0.
  - Otherwise, if `db_cnt == STABLE_CYCLES-1`: `level` toggles and `db_cnt` clears.
  - Otherwise, `db_cnt` increments.
  - A single-cycle agreement restarts the window, so a bounce shorter than `STABLE_CYCLES` never changes the level.
- **Edge pulses:** `btn_press` and `btn_release` are registered and assert in the same cycle the new `btn_level` value first appears.
- **Repeat FSM** (per channel, only when `REPEAT_EN=1`). States:
  - `IDLE`: level is 0.
  - `DELAY`: counting towards the first repeat.
  - `RPT`: counting between repeats.
- **Repeat transitions:**
  - `IDLE`→`DELAY` on press; `btn_key` pulses with `btn_press` and `rep_cnt` clears.
  - In `DELAY`, `rep_cnt` increments. When `rep_cnt == REPEAT_DELAY-1`: `btn_key` pulses, `rep_cnt` clears, go to `RPT`.
  - In `RPT`, when `rep_cnt == REPEAT_PERIOD-1`: `btn_key` pulses and `rep_cnt` clears.
  - Any state→`IDLE` on release; `rep_cnt` clears and no key pulse is issued.
  - `rep_cnt` is sized for max(REPEAT_DELAY, REPEAT_PERIOD).
- A release in the same cycle a repeat would fire: the release wins and no key pulse is issued.

## Timing
- **Reset values:** all outputs 0, FSMs in `IDLE`, all counters 0.
  - Reset is asynchronous, so outputs clear immediately on assertion, including mid-count or mid-repeat.
  - After deassertion, a button already held is treated as a fresh press and takes the full latency.
- **Press latency:** `btn_in` is stable high, first sampled at edge k. `btn_level`, `btn_press` and `btn_key` assert after edge k+STABLE_CYCLES+1, i.e. STABLE_CYCLES+2 edges including edge k.
- **Release latency:** the same, symmetric.
- **Pulse width:** every pulse is exactly one cycle. Press and release can never coincide on one channel.
- **Repeat timing:** the first repeat pulse comes REPEAT_DELAY cycles after the press pulse. Later repeats come every REPEAT_PERIOD cycles.
- **Simultaneous channels:** any set of channels may pulse in the same cycle.

## Structure
- **Package `btn_pkg`:**
  - Holds `CLK_HZ` (100_000_000) and the default constants `DB_MS`, `RPT_DELAY_MS` and `RPT_PERIOD_MS`.
  - Holds the derived cycle-count localparams used as parameter defaults.
  - Holds the repeat-state enum `rpt_state_t` (`IDLE`, `DELAY`, `RPT`).
- **Sub-module `btn_debounce_chan`:** holds the single-channel synchroniser, debounce counter, pulse logic and repeat FSM. The top level is a generate loop of `N_BTN` instances plus parameter-legality assertions.

## Test plan
All scenarios use `N_BTN`=5, `STABLE_CYCLES`=4, `REPEAT_DELAY`=10, `REPEAT_PERIOD`=3.
1. **Reset with a held button:** hold `rst_n_in` low with `btn_in`=5'b11111 → all outputs 0 throughout. Release reset → all `btn_level` bits rise together on the 6th edge, with one press and one key pulse each.
2. **Clean press on channel 0:** raise bit 0 at edge k → `btn_level[0]` and `btn_press[0]` appear after edge k+5. `btn_press` is high for exactly 1 cycle; other channels stay 0.
3. **Bounce rejection:** drive bit 1 with the pattern 3 cycles high, 1 cycle low, repeated 8 times → `btn_level[1]` stays 0 with no pulses. Then hold high → level rises after 6 edges.
4. **Auto-repeat:** hold bit 2 for 30 cycles after its press pulse → `btn_key[2]` pulses at +0, +10, +13, +16, +19, +22, +25, +28.
5. **Release and release-versus-repeat collision:**
   - Release bit 2 → `btn_release[2]` pulses after 6 edges and `btn_key[2]` stops.
   - Time the release so the debounced release lands on a repeat cycle → no key pulse in that cycle.
6. **Reset mid-operation:** assert `rst_n_in` while `db_cnt`=2 on channel 3 and channel 4 is in `RPT` → all outputs drop at once. After reset, channel 4 still held → fresh full-latency press.
